// File: rtl/rv_mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, owner encoding, wait-counter sizing.
// Latency: none (types and constants only).
// Backpressure: n/a.
package rv_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_DMA  = 1'b1
  } owner_t;

  // Largest legal memory latency; the wait counter is sized to hold it.
  localparam int MEM_LAT_MAX = 15;
  localparam int CNT_W       = $clog2(MEM_LAT_MAX + 1);

endpackage

// File: rtl/rv_mem_arb_if.sv
// Bundle of the two requester ports and the single memory port of rv_mem_arb.
// Latency: none (wires only).
// Backpressure: requesters hold req until gnt; memory has no backpressure.
interface rv_mem_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          core_req;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic          core_gnt;
  logic          core_rvalid;
  logic [DW-1:0] core_rdata;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt;
  logic          dma_rvalid;
  logic [DW-1:0] dma_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_gnt, core_rvalid, core_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Requester / memory side.
  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_gnt, core_rvalid, core_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/rv_rr_arb2.sv
// Two-request arbiter: round-robin on ties when RV_MEM_ARB_RR_EN is defined, else core-priority.
// Latency: combinational winner; last-owner register updates on the upd strobe.
// Backpressure: none; winner is only meaningful while at least one req is high.
module rv_rr_arb2
  import rv_mem_arb_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   req_core,
  input  logic   req_dma,
  input  logic   upd,
  input  owner_t upd_owner,
  output owner_t win
);

`ifdef RV_MEM_ARB_RR_EN
  owner_t last;

  // Remember who owned the access being issued; reset to DMA so core takes the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= OWN_DMA;
    end else if (upd) begin
      last <= upd_owner;
    end
  end

  // Single requester wins outright; a tie goes to whoever did not own the last access.
  always_comb begin
    win = OWN_CORE;
    if (req_core && req_dma) begin
      win = (last == OWN_CORE) ? OWN_DMA : OWN_CORE;
    end else if (req_dma) begin
      win = OWN_DMA;
    end
  end
`else
  // No history kept in fixed-priority mode, so the update path is left dangling.
  logic unused_upd;
  assign unused_upd = ^{clk, rst, upd, upd_owner};

  // Core wins every tie; DMA only wins when it requests alone.
  always_comb begin
    win = OWN_CORE;
    if (req_dma && !req_core) begin
      win = OWN_DMA;
    end
  end
`endif

endmodule

// File: rtl/rv_mem_arb.sv
// Shares the single-port unified memory between core and DMA, one access in flight (RV_MEM_ARB_RR_EN selects round-robin ties).
// Latency: req sampled at t -> gnt/mem_en at t+1, rvalid at t+2+MEM_LAT; one access per MEM_LAT+2 cycles.
// Backpressure: requesters hold req/we/addr/wdata until gnt; the loser simply keeps waiting.
module rv_mem_arb
  import rv_mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1   // legal range 1..MEM_LAT_MAX
)
(
  input  logic clk,
  input  logic rst,
  rv_mem_arb_if.slave bus
);

  localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LAT);

  state_t         state;
  owner_t         owner;
  owner_t         win;
  logic           r_we;
  logic [AW-1:0]  r_addr;
  logic [DW-1:0]  r_wdata;
  logic [DW-1:0]  resp;
  logic [CNT_W-1:0] cnt;

  logic           any_req;
  logic           sel_we;
  logic [AW-1:0]  sel_addr;
  logic [DW-1:0]  sel_wdata;
  logic           in_issue;
  logic           in_resp;

  assign any_req  = bus.core_req | bus.dma_req;
  assign in_issue = (state == ISSUE);
  assign in_resp  = (state == RESP);

  rv_rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_core  (bus.core_req),
    .req_dma   (bus.dma_req),
    .upd       (in_issue),
    .upd_owner (owner),
    .win       (win)
  );

  // Pick the winning requester's access fields for capture.
  always_comb begin
    sel_we    = bus.core_we;
    sel_addr  = bus.core_addr;
    sel_wdata = bus.core_wdata;
    if (win == OWN_DMA) begin
      sel_we    = bus.dma_we;
      sel_addr  = bus.dma_addr;
      sel_wdata = bus.dma_wdata;
    end
  end

  // Access sequencer: arbitrate in IDLE/RESP, issue once, wait out the latency, respond once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= OWN_CORE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      resp    <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE, RESP: begin
          // RESP arbitrates too, so back-to-back accesses skip IDLE.
          if (any_req) begin
            owner   <= win;
            r_we    <= sel_we;
            r_addr  <= sel_addr;
            r_wdata <= sel_wdata;
            state   <= ISSUE;
          end else begin
            state   <= IDLE;
          end
        end
        ISSUE: begin
          cnt   <= LAT;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == 1) begin
            // Writes return zero data; reads take the memory output on its valid cycle.
            resp  <= r_we ? '0 : bus.mem_rdata;
            state <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state only, so reset zeroes them immediately.
  assign bus.mem_en      = in_issue;
  assign bus.mem_we      = in_issue & r_we;
  assign bus.mem_addr    = in_issue ? r_addr  : '0;
  assign bus.mem_wdata   = in_issue ? r_wdata : '0;

  assign bus.core_gnt    = in_issue && (owner == OWN_CORE);
  assign bus.dma_gnt     = in_issue && (owner == OWN_DMA);
  assign bus.core_rvalid = in_resp  && (owner == OWN_CORE);
  assign bus.dma_rvalid  = in_resp  && (owner == OWN_DMA);
  assign bus.core_rdata  = (in_resp && (owner == OWN_CORE)) ? resp : '0;
  assign bus.dma_rdata   = (in_resp && (owner == OWN_DMA))  ? resp : '0;

endmodule

// File: tb/tb_rv_mem_arb.sv
// Directed bench for rv_mem_arb at MEM_LAT 1, 3 and 15, with a pipelined memory model per instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_rv_mem_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  rv_mem_arb_if #(.AW(32), .DW(32)) ifa ();
  rv_mem_arb_if #(.AW(32), .DW(32)) ifb ();
  rv_mem_arb_if #(.AW(32), .DW(32)) ifc ();

  rv_mem_arb #(.AW(32), .DW(32), .MEM_LAT(1))  u_a (.clk(clk), .rst(rst), .bus(ifa));
  rv_mem_arb #(.AW(32), .DW(32), .MEM_LAT(3))  u_b (.clk(clk), .rst(rst), .bus(ifb));
  rv_mem_arb #(.AW(32), .DW(32), .MEM_LAT(15)) u_c (.clk(clk), .rst(rst), .bus(ifc));

  always #5 clk = ~clk;

  // Memory contents: one marked word, everything else is the inverted address.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : ~a;
  endfunction

  logic [15:0] va, vb, vc;
  logic [31:0] da [16];
  logic [31:0] db [16];
  logic [31:0] dc [16];

  // Memory model valid pipeline: data appears exactly MEM_LAT cycles after the mem_en cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      va <= '0;
      vb <= '0;
      vc <= '0;
    end else begin
      va <= {va[14:0], ifa.mem_en};
      vb <= {vb[14:0], ifb.mem_en};
      vc <= {vc[14:0], ifc.mem_en};
    end
  end

  // Memory model data pipeline, looked up from the address on the issue cycle.
  always @(posedge clk) begin
    da[0] <= mem_val(ifa.mem_addr);
    db[0] <= mem_val(ifb.mem_addr);
    dc[0] <= mem_val(ifc.mem_addr);
    for (int k = 1; k < 16; k++) begin
      da[k] <= da[k-1];
      db[k] <= db[k-1];
      dc[k] <= dc[k-1];
    end
  end

  assign ifa.mem_rdata = va[0]  ? da[0]  : 32'h0;
  assign ifb.mem_rdata = vb[2]  ? db[2]  : 32'h0;
  assign ifc.mem_rdata = vc[14] ? dc[14] : 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hang guard.
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ed;
    int ph;
    int seen;
    int en_cnt;
    int early;

    ifa.core_req = 0; ifa.core_we = 0; ifa.core_addr = 0; ifa.core_wdata = 0;
    ifa.dma_req  = 0; ifa.dma_we  = 0; ifa.dma_addr  = 0; ifa.dma_wdata  = 0;
    ifb.core_req = 0; ifb.core_we = 0; ifb.core_addr = 0; ifb.core_wdata = 0;
    ifb.dma_req  = 0; ifb.dma_we  = 0; ifb.dma_addr  = 0; ifb.dma_wdata  = 0;
    ifc.core_req = 0; ifc.core_we = 0; ifc.core_addr = 0; ifc.core_wdata = 0;
    ifc.dma_req  = 0; ifc.dma_we  = 0; ifc.dma_addr  = 0; ifc.dma_wdata  = 0;

    // ---- Reset state ----
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_mem", {ifa.mem_en, ifa.mem_we, ifa.mem_addr[29:0]}, 0);
    chk("rst_a_gnt", {ifa.core_gnt, ifa.dma_gnt}, 0);
    chk("rst_a_rvalid", {ifa.core_rvalid, ifa.dma_rvalid}, 0);
    chk("rst_a_rdata", ifa.core_rdata | ifa.dma_rdata, 0);
    chk("rst_b_any", {ifb.mem_en, ifb.core_gnt, ifb.dma_gnt, ifb.core_rvalid, ifb.dma_rvalid}, 0);
    chk("rst_c_any", {ifc.mem_en, ifc.core_gnt, ifc.dma_gnt, ifc.core_rvalid, ifc.dma_rvalid}, 0);
    rst = 0;
    step();
    step();

    // ---- Both requesters held for four accesses (A, MEM_LAT=1, fresh out of reset) ----
    ifa.core_req = 1; ifa.core_we = 0; ifa.core_addr = 32'h100;
    ifa.dma_req  = 1; ifa.dma_we  = 0; ifa.dma_addr  = 32'h200;
    for (int i = 0; i < 12; i++) begin
      step();
      ph = i % 3;
`ifdef RV_MEM_ARB_RR_EN
      ed = (i / 3) % 2;
`else
      ed = 0;
`endif
      if (ph == 0) begin
        chk("both_core_gnt", ifa.core_gnt, (ed == 0) ? 1 : 0);
        chk("both_dma_gnt", ifa.dma_gnt, (ed == 1) ? 1 : 0);
        chk("both_mem_addr", ifa.mem_addr, (ed == 1) ? 32'h200 : 32'h100);
      end else if (ph == 1) begin
        chk("both_wait_quiet", {ifa.mem_en, ifa.core_gnt, ifa.dma_gnt, ifa.core_rvalid, ifa.dma_rvalid}, 0);
      end else begin
        chk("both_core_rvalid", ifa.core_rvalid, (ed == 0) ? 1 : 0);
        chk("both_dma_rvalid", ifa.dma_rvalid, (ed == 1) ? 1 : 0);
        chk("both_rdata", ifa.core_rdata | ifa.dma_rdata, (ed == 1) ? 32'hFFFFFDFF : 32'hFFFFFEFF);
        chk("both_resp_no_en", ifa.mem_en, 0);
      end
      if (i == 9) begin
        ifa.core_req = 0;
        ifa.dma_req  = 0;
      end
    end
    step();
    chk("both_idle_after", {ifa.mem_en, ifa.core_gnt, ifa.dma_gnt}, 0);
    ifa.core_addr = 0; ifa.dma_addr = 0;
    step();

    // ---- Core read alone (A, MEM_LAT=1) ----
    ifa.core_req = 1; ifa.core_we = 0; ifa.core_addr = 32'h10;
    step();
    chk("rd_core_gnt", ifa.core_gnt, 1);
    chk("rd_dma_gnt", ifa.dma_gnt, 0);
    chk("rd_mem_en", ifa.mem_en, 1);
    chk("rd_mem_we", ifa.mem_we, 0);
    chk("rd_mem_addr", ifa.mem_addr, 32'h10);
    step();
    ifa.core_req = 0; ifa.core_addr = 0;
    chk("rd_wait_mem_en", ifa.mem_en, 0);
    chk("rd_wait_mem_addr", ifa.mem_addr, 0);
    chk("rd_wait_rvalid", ifa.core_rvalid, 0);
    step();
    chk("rd_core_rvalid", ifa.core_rvalid, 1);
    chk("rd_core_rdata", ifa.core_rdata, 32'hDEADBEEF);
    chk("rd_dma_quiet", {ifa.dma_gnt, ifa.dma_rvalid, ifa.dma_rdata[29:0]}, 0);
    chk("rd_no_gnt_with_rvalid", ifa.core_gnt, 0);
    step();
    chk("rd_rvalid_pulse", ifa.core_rvalid, 0);
    chk("rd_rdata_clear", ifa.core_rdata, 0);

    // ---- DMA write (B, MEM_LAT=3) ----
    ifb.dma_req = 1; ifb.dma_we = 1; ifb.dma_addr = 32'h40; ifb.dma_wdata = 32'h12345678;
    step();
    chk("wr_dma_gnt", ifb.dma_gnt, 1);
    chk("wr_core_gnt", ifb.core_gnt, 0);
    chk("wr_mem_en_we", {ifb.mem_en, ifb.mem_we}, 2'b11);
    chk("wr_mem_addr", ifb.mem_addr, 32'h40);
    chk("wr_mem_wdata", ifb.mem_wdata, 32'h12345678);
    step();
    ifb.dma_req = 0; ifb.dma_we = 0; ifb.dma_addr = 0; ifb.dma_wdata = 0;
    for (int i = 2; i <= 4; i++) begin
      chk("wr_wait_quiet", {ifb.mem_en, ifb.mem_we, ifb.dma_rvalid}, 0);
      step();
    end
    chk("wr_dma_rvalid", ifb.dma_rvalid, 1);
    chk("wr_dma_rdata", ifb.dma_rdata, 0);
    chk("wr_core_rvalid", ifb.core_rvalid, 0);
    step();
    chk("wr_rvalid_pulse", ifb.dma_rvalid, 0);

    // ---- Asynchronous reset during ISSUE (B) ----
    ifb.core_req = 1; ifb.core_we = 0; ifb.core_addr = 32'h20;
    step();
    chk("rsti_mem_en_before", ifb.mem_en, 1);
    #2;
    rst = 1;
    #1;
    chk("rsti_async_clear", {ifb.mem_en, ifb.core_gnt, ifb.mem_addr[29:0]}, 0);
    ifb.core_req = 0; ifb.core_addr = 0;
    step();
    rst = 0;
    step();

    // ---- Reset during WAIT of a core read (B) ----
    ifb.core_req = 1; ifb.core_we = 0; ifb.core_addr = 32'h24;
    step();
    step();
    ifb.core_req = 0; ifb.core_addr = 0;
    #2;
    rst = 1;
    #1;
    chk("rstw_outputs_zero", {ifb.mem_en, ifb.core_gnt, ifb.dma_gnt, ifb.core_rvalid, ifb.dma_rvalid}, 0);
    step();
    rst = 0;
    seen = 0;
    repeat (8) begin
      step();
      seen += int'(ifb.core_rvalid);
    end
    chk("rstw_no_rvalid", seen, 0);

    // New core read after reset release (B)
    ifb.core_req = 1; ifb.core_we = 0; ifb.core_addr = 32'h10;
    step();
    chk("rstw_new_gnt", ifb.core_gnt, 1);
    chk("rstw_new_addr", ifb.mem_addr, 32'h10);
    step();
    ifb.core_req = 0; ifb.core_addr = 0;
    step();
    step();
    chk("rstw_new_not_early", ifb.core_rvalid, 0);
    step();
    chk("rstw_new_rvalid", ifb.core_rvalid, 1);
    chk("rstw_new_rdata", ifb.core_rdata, 32'hDEADBEEF);

    // ---- Single DMA read at maximum latency (C, MEM_LAT=15) ----
    ifc.dma_req = 1; ifc.dma_we = 0; ifc.dma_addr = 32'h80;
    en_cnt = 0;
    early  = 0;
    for (int i = 1; i <= 17; i++) begin
      step();
      en_cnt += int'(ifc.mem_en);
      if (i == 1) chk("lat15_gnt", ifc.dma_gnt, 1);
      if (i == 2) begin
        ifc.dma_req = 0;
        ifc.dma_addr = 0;
      end
      if (i < 17) begin
        early += int'(ifc.dma_rvalid);
      end else begin
        chk("lat15_rvalid", ifc.dma_rvalid, 1);
        chk("lat15_rdata", ifc.dma_rdata, 32'hFFFFFF7F);
      end
    end
    chk("lat15_mem_en_count", en_cnt, 1);
    chk("lat15_no_early_rvalid", early, 0);
    step();
    chk("lat15_rvalid_pulse", ifc.dma_rvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rv_mem_arb.md
# rv_mem_arb

Two-port arbiter and sequencer for the single-port unified memory of the multicycle RISC-V core. It shares the memory between the core's control plane (instruction fetch, LW/SW) and a DMA/test-loader port. Only one access is in flight at a time. Each access is issued, the fixed memory latency is waited out, and the read data (or write acknowledge) is returned to the granted requester.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- MEM_LAT, 1, cycles from the mem_en cycle to valid mem_rdata; legal range 1..15

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- core_req / dma_req  in  1  access request; held with its we/addr/wdata until gnt
- core_we / dma_we  in  1  1 = write, 0 = read
- core_addr / dma_addr  in  AW  byte address
- core_wdata / dma_wdata  in  DW  write data
- core_gnt / dma_gnt  out  1  one-cycle pulse; request accepted this cycle
- core_rvalid / dma_rvalid  out  1  one-cycle pulse; access complete
- core_rdata / dma_rdata  out  DW  read data, valid with rvalid; 0 for writes
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after mem_en

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is high, arbitrate, register owner and the owner's we/addr/wdata, then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (one cycle):
  - mem_en=1; mem_we/mem_addr/mem_wdata come from the registered request.
  - The owner's gnt=1.
  - Load wait counter with MEM_LAT; go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle the counter equals 1: capture mem_rdata into the response register (0 if write), then go to RESP.
- RESP (one cycle):
  - The owner's rvalid=1; the owner's rdata = response register.
  - Arbitrate exactly as in IDLE. If a req is high, go to ISSUE; otherwise go to IDLE.
- Arbitration: if only one req is high, that requester wins. The tie rule is set by RR_EN (see Configuration).
- A requester must drop req in the cycle after its gnt unless it is posting a new access. Any req high in IDLE or RESP is a new access.
- Non-owner outputs: gnt=0, rvalid=0, rdata=0.
- When mem_en=0, mem_we, mem_addr and mem_wdata are driven 0.
- Reset, asynchronous and honoured mid-access:
  - state=IDLE, owner=CORE, last owner=DMA, counter=0, response register=0.
  - All outputs are 0.
  - An in-flight access is abandoned and no rvalid is issued for it.

## Timing
- A request sampled in IDLE at cycle t gives: ISSUE (gnt, mem_en) at t+1, WAIT at t+2..t+1+MEM_LAT, rvalid at t+2+MEM_LAT.
- Access latency from req to rvalid is MEM_LAT+2 cycles.
- Back-to-back throughput: one access per MEM_LAT+2 cycles, because RESP overlaps arbitration.
- gnt and rvalid are never asserted in the same cycle.
- rvalid is never asserted to both ports in the same cycle.
- mem_en is high for exactly one cycle per access.
- A req that drops before it is granted is simply never serviced. No error is flagged.

## Configuration
- Macro: RV_MEM_ARB_RR_EN.
- Defined (round-robin):
  - Ties go to the port that did not own the previous access.
  - The last-owner register updates in every ISSUE cycle.
  - Out of reset, core wins the first tie.
- Undefined (fixed priority):
  - Core always wins ties; DMA can be starved.
  - The last-owner register is not implemented.

## Structure
- Package rv_mem_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP)
  - the owner enum (OWN_CORE, OWN_DMA)
  - the MEM_LAT legality constant MEM_LAT_MAX=15
- Sub-module rv_rr_arb2 is the two-request arbiter.
  - It contains the last-owner register and the RV_MEM_ARB_RR_EN logic.
  - Inputs: req pair, an update strobe driven in ISSUE.
  - Output: winner.
- The top level holds the FSM, wait counter, request/response registers and the output muxing.

## Test plan
- Core read alone, MEM_LAT=1, core_addr=0x10, mem returns 0xDEADBEEF → core_gnt at t+1, mem_en one cycle with mem_addr=0x10, core_rvalid at t+3 with core_rdata=0xDEADBEEF; DMA outputs stay 0.
- DMA write, MEM_LAT=3, dma_addr=0x40, dma_wdata=0x12345678 → mem_en=mem_we=1 at t+1 with those values; dma_rvalid at t+5 with dma_rdata=0.
- Both req held continuously for 4 accesses, RR_EN defined → grant order CORE, DMA, CORE, DMA; one access per MEM_LAT+2 cycles with no IDLE cycle between.
- Same stimulus, RR_EN undefined → grant order CORE, CORE, CORE, CORE; dma_gnt never asserted.
- rst pulsed during WAIT of a core read → all outputs 0 immediately, no core_rvalid ever for that access; a new core_req after release is serviced with normal latency.
- Single DMA request, MEM_LAT=15 → rvalid exactly 17 cycles after req is sampled; mem_en high for exactly 1 cycle.
